// File: rtl/ha_array_pkg.sv
// Shared types and helpers for the half-adder array reduction pipeline.
// Row weighting is kept here so every consumer agrees on bit positions.
package ha_array_pkg;

    localparam int NUM_ROWS = 4;
    localparam int T_W      = 9;
    localparam int B_W      = 7;
    localparam int PROD_W   = 16;
    localparam int SUM_W    = 18;

    typedef struct packed {
        logic [T_W-1:0] t;
        logic [B_W-1:0] b;
    } ha_row_t;

    // Row k value: (t + (b << 2)) << 2k, at full 18-bit width.
    function automatic logic [SUM_W-1:0] row_weight(
        input logic [T_W-1:0] t,
        input logic [B_W-1:0] b,
        input int             k
    );
        logic [SUM_W-1:0] v;
        v = SUM_W'(t) + (SUM_W'(b) << 2);
        return v << (2 * k);
    endfunction

endpackage

// File: rtl/ha_array_reduce_pipe_ha_row_pair_add.sv
// Combinational weighted sum of two adjacent compressed rows.
// K is the index of the lower row of the pair.
module ha_row_pair_add
    import ha_array_pkg::*;
#(
    parameter int K = 0
) (
    input  ha_row_t          i_row_a,
    input  ha_row_t          i_row_b,
    output logic [SUM_W-1:0] o_sum
);

    assign o_sum = row_weight(i_row_a.t, i_row_a.b, K)
                 + row_weight(i_row_b.t, i_row_b.b, K + 1);

endmodule

// File: rtl/ha_array_reduce_pipe.sv
// Two-stage valid/ready final adder for the approximate 8x8 multiplier,
// with optional saturation and a multiply-accumulate register.
module ha_array_reduce_pipe
    import ha_array_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [T_W-1:0]   ha_array_0_t,
    input  logic [T_W-1:0]   ha_array_1_t,
    input  logic [T_W-1:0]   ha_array_2_t,
    input  logic [T_W-1:0]   ha_array_3_t,
    input  logic [B_W-1:0]   ha_array_0_b,
    input  logic [B_W-1:0]   ha_array_1_b,
    input  logic [B_W-1:0]   ha_array_2_b,
    input  logic [B_W-1:0]   ha_array_3_b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PROD_W-1:0] prod,
    output logic             prod_sat,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    ha_row_t          w_row [NUM_ROWS];
    logic [SUM_W-1:0] w_s01;
    logic [SUM_W-1:0] w_s23;
    logic [SUM_W-1:0] w_sum;
    logic             w_ovf;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W:0]   w_acc_add;
    logic             w_s1_load;
    logic             w_s2_load;

    logic             r_s1_valid;
    logic [SUM_W-1:0] r_s01;
    logic [SUM_W-1:0] r_s23;
    logic             r_s1_acc_en;
    logic             r_s1_acc_clr;

    logic             r_s2_valid;
    logic [PROD_W-1:0] r_prod;
    logic             r_prod_sat;
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_ovf;

    assign w_row[0] = {ha_array_0_t, ha_array_0_b};
    assign w_row[1] = {ha_array_1_t, ha_array_1_b};
    assign w_row[2] = {ha_array_2_t, ha_array_2_b};
    assign w_row[3] = {ha_array_3_t, ha_array_3_b};

    ha_row_pair_add #(.K(0)) u_pair01 (
        .i_row_a (w_row[0]),
        .i_row_b (w_row[1]),
        .o_sum   (w_s01)
    );

    ha_row_pair_add #(.K(2)) u_pair23 (
        .i_row_a (w_row[2]),
        .i_row_b (w_row[3]),
        .o_sum   (w_s23)
    );

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_sum     = r_s01 + r_s23;
    assign w_ovf     = |w_sum[SUM_W-1:PROD_W];
    assign w_prod    = (w_ovf && SAT_EN) ? '1 : w_sum[PROD_W-1:0];
    assign w_acc_add = {1'b0, r_acc} + (ACC_W+1)'(w_prod);

    // Stage 1: capture the two pair sums and the accumulate controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s01        <= '0;
            r_s23        <= '0;
            r_s1_acc_en  <= 1'b0;
            r_s1_acc_clr <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s01        <= w_s01;
                r_s23        <= w_s23;
                r_s1_acc_en  <= acc_en;
                r_s1_acc_clr <= acc_clr;
            end
        end
    end

    // Stage 2: final add, overflow handling and accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_prod     <= '0;
            r_prod_sat <= 1'b0;
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_prod     <= w_prod;
                r_prod_sat <= w_ovf;
                if (r_s1_acc_clr) begin
                    r_acc     <= r_s1_acc_en ? ACC_W'(w_prod) : '0;
                    r_acc_ovf <= 1'b0;
                end else if (r_s1_acc_en) begin
                    r_acc     <= w_acc_add[ACC_W-1:0];
                    r_acc_ovf <= r_acc_ovf | w_acc_add[ACC_W];
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign prod      = r_prod;
    assign prod_sat  = r_prod_sat;
    assign acc       = r_acc;
    assign acc_ovf   = r_acc_ovf;

endmodule

// File: tb/tb_ha_array_reduce_pipe.sv
// Directed bench for ha_array_reduce_pipe: one default instance and one
// with ACC_W=16, SAT_EN=0, both driven by the same stimulus.
module tb_ha_array_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        acc_en = 1'b0;
    logic        acc_clr = 1'b0;
    logic [8:0]  t0, t1, t2, t3;
    logic [6:0]  b0, b1, b2, b3;

    logic        in_ready, out_valid, prod_sat, acc_ovf;
    logic [15:0] prod;
    logic [23:0] acc;

    logic        in_ready2, out_valid2, prod_sat2, acc_ovf2;
    logic [15:0] prod2;
    logic [15:0] acc2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ha_array_reduce_pipe #(.ACC_W(24), .SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ha_array_0_t(t0), .ha_array_1_t(t1),
        .ha_array_2_t(t2), .ha_array_3_t(t3),
        .ha_array_0_b(b0), .ha_array_1_b(b1),
        .ha_array_2_b(b2), .ha_array_3_b(b3),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .prod_sat(prod_sat),
        .acc(acc), .acc_ovf(acc_ovf)
    );

    ha_array_reduce_pipe #(.ACC_W(16), .SAT_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .ha_array_0_t(t0), .ha_array_1_t(t1),
        .ha_array_2_t(t2), .ha_array_3_t(t3),
        .ha_array_0_b(b0), .ha_array_1_b(b1),
        .ha_array_2_b(b2), .ha_array_3_b(b3),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready),
        .prod(prod2), .prod_sat(prod_sat2),
        .acc(acc2), .acc_ovf(acc_ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic zero_rows();
        t0 = '0; t1 = '0; t2 = '0; t3 = '0;
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;
    endtask

    // Accept one bundle, then check it shows up exactly two cycles later.
    task automatic send1(input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    endtask

    // Push ten prod=100 bundles, clearing on the first; random=1 stalls.
    task automatic stream(input string tag, input bit rnd);
        int sent = 0;
        int got = 0;
        int its = 0;
        bit take_in, take_out, stalled;
        logic [15:0] h_prod;
        logic [23:0] h_acc;
        stalled = 1'b0;
        h_prod = '0;
        h_acc = '0;
        zero_rows();
        t0 = 9'd100;
        acc_en = 1'b1;
        while (got < 10 && its < 200) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = (sent < 10);
            acc_clr = (sent == 0);
            #1;
            take_in = in_valid && in_ready;
            take_out = out_valid && out_ready;
            if (stalled) begin
                chk({tag, "_hold_prod"}, 32'(prod), 32'(h_prod));
                chk({tag, "_hold_acc"}, 32'(acc), 32'(h_acc));
            end
            if (take_out) begin
                got++;
                chk({tag, "_prod"}, 32'(prod), 32'd100);
                chk({tag, "_acc"}, 32'(acc), 32'(got * 100));
            end
            stalled = out_valid && !out_ready;
            h_prod = prod;
            h_acc = acc;
            @(posedge clk);
            if (take_in) sent++;
            its++;
        end
        chk({tag, "_count"}, 32'(got), 32'd10);
        if (!rnd) chk({tag, "_cycles"}, 32'(its), 32'd12);
        #1 in_valid = 1'b0;
        acc_clr = 1'b0;
        acc_en = 1'b0;
    endtask

    initial begin
        zero_rows();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_prod", 32'(prod), 32'd0);
        chk("rst_sat", 32'(prod_sat), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_ovf", 32'(acc_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_ready", 32'(in_ready), 32'd1);

        zero_rows();
        t0 = 9'd1;
        send1("one");
        chk("one_prod", 32'(prod), 32'd1);
        chk("one_sat", 32'(prod_sat), 32'd0);
        chk("one_acc", 32'(acc), 32'd0);

        zero_rows();
        b3 = 7'h40;
        send1("b3");
        chk("b3_prod", 32'(prod), 32'd16384);

        zero_rows();
        t2 = 9'h100;
        send1("t2");
        chk("t2_prod", 32'(prod), 32'd4096);

        t0 = 9'h1FF; t1 = 9'h1FF; t2 = 9'h1FF; t3 = 9'h1FF;
        b0 = 7'h7F; b1 = 7'h7F; b2 = 7'h7F; b3 = 7'h7F;
        send1("max");
        chk("max_prod_sat", 32'(prod), 32'hFFFF);
        chk("max_sat_sat", 32'(prod_sat), 32'd1);
        chk("max_prod_wrap", 32'(prod2), 32'd21079);
        chk("max_sat_wrap", 32'(prod_sat2), 32'd1);

        zero_rows();
        t3 = 9'd511; b3 = 7'd126; t0 = 9'd40;
        acc_clr = 1'b1; acc_en = 1'b1;
        send1("a65000");
        chk("a65000_acc2", 32'(acc2), 32'd65000);
        chk("a65000_ovf2", 32'(acc_ovf2), 32'd0);
        zero_rows();
        t0 = 9'd500; b0 = 7'd125;
        acc_clr = 1'b0; acc_en = 1'b1;
        send1("a1000");
        chk("a1000_prod", 32'(prod), 32'd1000);
        chk("a1000_acc2", 32'(acc2), 32'd464);
        chk("a1000_ovf2", 32'(acc_ovf2), 32'd1);
        chk("a1000_acc", 32'(acc), 32'd66000);
        chk("a1000_ovf", 32'(acc_ovf), 32'd0);
        acc_clr = 1'b1; acc_en = 1'b0;
        send1("aclr");
        chk("aclr_acc2", 32'(acc2), 32'd0);
        chk("aclr_ovf2", 32'(acc_ovf2), 32'd0);
        acc_clr = 1'b0;

        stream("full", 1'b0);
        stream("rand", 1'b1);

        @(negedge clk);
        zero_rows();
        t0 = 9'd100;
        acc_clr = 1'b1; acc_en = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("fill_valid", 32'(out_valid), 32'd1);
        chk("fill_acc", 32'(acc), 32'd100);
        chk("fill_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        acc_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_acc", 32'(acc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
